// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one synchronous single-port RAM between an instruction-fetch port
//   and a load/store port. A three-state FSM (IDLE / INST_BUSY / DATA_BUSY)
//   samples requests only while idle, issues a one-cycle RAM access, then
//   stays busy for MEM_LATENCY cycles before pulsing the requester's done.
//   Data requests win ties.
//
//   Request codes : MEM_NOP=0, MEM_READ=1, MEM_WRITE=2
//   Status codes  : MEM_RESTING=0, MEM_INST_WORKING=1, MEM_DATA_WORKING=2
//
//   Optional build macro ARB_STARVE_GUARD_EN: after STARVE_LIMIT data grants
//   made while an instruction fetch waited, the next idle arbitration serves
//   the fetch. Undefined: strict data priority, no counter.
//
// Ports
//   clk, rst_n                          clock, async active-low reset
//   inst_vis_signal/inst_vis_addr       fetch request, held until inst_done
//   inst_data                           last fetched word
//   data_vis_signal/data_vis_addr/
//   data_wdata                          load/store request, held until data_done
//   data_rdata                          last loaded word (stores leave it alone)
//   mem_status                          registered FSM state
//   inst_done, data_done                one-cycle completion pulses
//   ram_en, ram_we, ram_addr, ram_wdata RAM command (addr/wdata held while busy)
//   ram_rdata                           RAM read data, valid cycle after ram_en
module memory_arbiter #(
    parameter int ADDR_WIDTH   = 17,
    parameter int LEN          = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            inst_vis_signal,
    input  logic [ADDR_WIDTH-1:0] inst_vis_addr,
    output logic [LEN-1:0]        inst_data,
    input  logic [1:0]            data_vis_signal,
    input  logic [ADDR_WIDTH-1:0] data_vis_addr,
    input  logic [LEN-1:0]        data_wdata,
    output logic [LEN-1:0]        data_rdata,
    output logic [1:0]            mem_status,
    output logic                  inst_done,
    output logic                  data_done,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [LEN-1:0]        ram_wdata,
    input  logic [LEN-1:0]        ram_rdata
);
    localparam logic [1:0] MEM_NOP          = 2'd0;
    localparam logic [1:0] MEM_WRITE        = 2'd2;
    localparam logic [1:0] MEM_RESTING      = 2'd0;
    localparam logic [1:0] MEM_INST_WORKING = 2'd1;
    localparam logic [1:0] MEM_DATA_WORKING = 2'd2;

    localparam logic [3:0] LAT4 = 4'(MEM_LATENCY);
    // With a single busy cycle the RAM word only appears in the done cycle,
    // so it is forwarded straight through and registered at the end of it.
    localparam bit LAT1 = (MEM_LATENCY == 1);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("memory_arbiter: MEM_LATENCY must be 1..15");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve
        $error("memory_arbiter: STARVE_LIMIT must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_INST = 2'd1, S_DATA = 2'd2} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic                  r_is_wr;
    logic                  r_ram_en, r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [LEN-1:0]        r_ram_wdata;
    logic [LEN-1:0]        r_inst_data, r_data_rdata;
    logic                  r_inst_done, r_data_done;

    logic w_inst_pend, w_data_pend, w_data_wr;
    logic w_grant_inst, w_grant_data, w_last, w_starved;
    logic w_cap_inst, w_cap_data;

    assign w_inst_pend = (inst_vis_signal != MEM_NOP);
    assign w_data_pend = (data_vis_signal != MEM_NOP);
    assign w_data_wr   = (data_vis_signal == MEM_WRITE);
    assign w_last      = (r_cnt == 4'd1);

`ifdef ARB_STARVE_GUARD_EN
    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    logic [SW-1:0] r_starve;

    assign w_starved = (r_starve >= STARVE_MAX);

    // Counts data grants that overtook a waiting fetch; saturates at the
    // limit because the next idle arbitration then serves the fetch anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_starve <= '0;
        else if (w_grant_inst)
            r_starve <= '0;
        else if (w_grant_data && w_inst_pend && !w_starved)
            r_starve <= r_starve + SW'(1);
    end
`else
    assign w_starved = 1'b0;
`endif

    // Next-state / grant decision
    always_comb begin
        w_next       = r_state;
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_inst_pend && (!w_data_pend || w_starved)) begin
                    w_grant_inst = 1'b1;
                    w_next       = S_INST;
                end else if (w_data_pend) begin
                    w_grant_data = 1'b1;
                    w_next       = S_DATA;
                end
            end
            default: if (w_last) w_next = S_IDLE;
        endcase
    end

    assign w_cap_inst = LAT1 ? r_inst_done : (r_state == S_INST && w_last);
    assign w_cap_data = LAT1 ? (r_data_done && !r_is_wr)
                             : (r_state == S_DATA && w_last && !r_is_wr);

    // State register and registered datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_is_wr      <= 1'b0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_inst_data  <= '0;
            r_data_rdata <= '0;
            r_inst_done  <= 1'b0;
            r_data_done  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_ram_en    <= w_grant_inst | w_grant_data;
            r_ram_we    <= w_grant_data & w_data_wr;
            r_inst_done <= (r_state == S_INST) & w_last;
            r_data_done <= (r_state == S_DATA) & w_last;
            if (w_grant_inst || w_grant_data)
                r_cnt <= LAT4;
            else if (r_state != S_IDLE)
                r_cnt <= r_cnt - 4'd1;
            if (w_grant_inst)
                r_ram_addr <= inst_vis_addr;
            if (w_grant_data) begin
                r_ram_addr  <= data_vis_addr;
                r_ram_wdata <= data_wdata;
                r_is_wr     <= w_data_wr;
            end
            if (w_cap_inst) r_inst_data  <= ram_rdata;
            if (w_cap_data) r_data_rdata <= ram_rdata;
        end
    end

    // Outputs
    always_comb begin
        case (r_state)
            S_INST:  mem_status = MEM_INST_WORKING;
            S_DATA:  mem_status = MEM_DATA_WORKING;
            default: mem_status = MEM_RESTING;
        endcase
    end

    assign inst_data  = (LAT1 && r_inst_done) ? ram_rdata : r_inst_data;
    assign data_rdata = (LAT1 && r_data_done && !r_is_wr) ? ram_rdata : r_data_rdata;
    assign inst_done  = r_inst_done;
    assign data_done  = r_data_done;
    assign ram_en     = r_ram_en;
    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_memory_arbiter;
    localparam int AW = 17, LW = 32, LAT = 2, SLIM = 4;
    localparam logic [1:0] NOP = 2'd0, RD = 2'd1, WR = 2'd2;
    localparam logic [1:0] ST_R = 2'd0, ST_I = 2'd1, ST_D = 2'd2;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [1:0]    inst_sig = NOP, data_sig = NOP;
    logic [AW-1:0] inst_addr = '0, data_addr = '0;
    logic [LW-1:0] data_wdata = '0;
    logic [LW-1:0] inst_data, data_rdata, ram_wdata;
    logic [LW-1:0] ram_rdata = '0;
    logic [1:0]    mem_status;
    logic          inst_done, data_done, ram_en, ram_we;
    logic [AW-1:0] ram_addr;

    memory_arbiter #(.ADDR_WIDTH(AW), .LEN(LW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_vis_signal(inst_sig), .inst_vis_addr(inst_addr), .inst_data(inst_data),
        .data_vis_signal(data_sig), .data_vis_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .mem_status(mem_status),
        .inst_done(inst_done), .data_done(data_done),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM environment: read data appears the cycle after ram_en
    // and holds until the next access.
    logic [LW-1:0] ram [0:1023];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr[11:2]] <= ram_wdata;
            else        ram_rdata <= ram[ram_addr[11:2]];
        end
    end

    // Reference model state (transaction level)
    logic [LW-1:0] ref_mem [0:1023];
    int            cyc = 0, m_owner = 0, m_gcyc = 0, m_starve = 0;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wd;
    logic [1:0]    e_status;
    logic          e_en, e_we, e_idone, e_ddone;
    logic [LW-1:0] e_idata, e_drdata, e_wdata;
    logic [AW-1:0] e_addr;
    bit            data_cont = 0;
    int            n_vec = 0, n_err = 0;
    int            en_hi = 0, we_hi = 0, dd_hi = 0;
    logic [AW-1:0] last_en_addr = '0;
    int            glog[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        return AW'($urandom_range(0, 1023) << 2);
    endfunction

    function automatic bit starve_hit();
`ifdef ARB_STARVE_GUARD_EN
        return m_starve >= SLIM;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_owner = 0; m_starve = 0;
        e_status = ST_R; e_en = 0; e_we = 0; e_idone = 0; e_ddone = 0;
        e_idata = '0; e_drdata = '0; e_wdata = '0; e_addr = '0;
    endtask

    // One clock: advance the model for this edge, compare, then let the
    // requesters drop (or renew) a request whose done the model predicts.
    task automatic step();
        bit ip, dp, gi;
        @(posedge clk);
        cyc++;
        e_en = 0; e_we = 0; e_idone = 0; e_ddone = 0;
        if (!rst_n) begin
            model_reset();
        end else if (m_owner == 0) begin
            ip = (inst_sig != NOP);
            dp = (data_sig != NOP);
            gi = ip && (!dp || starve_hit());
            if (gi) begin
                m_owner = 1; m_starve = 0; m_addr = inst_addr; m_wr = 0;
            end else if (dp) begin
                m_owner = 2; if (ip) m_starve++;
                m_addr = data_addr; m_wr = (data_sig == WR);
                m_wd = data_wdata; e_wdata = data_wdata;
            end
            if (m_owner != 0) begin
                m_gcyc = cyc; e_en = 1; e_we = m_wr; e_addr = m_addr;
            end
        end else if (cyc == m_gcyc + LAT) begin
            if (m_owner == 1) begin
                e_idone = 1; e_idata = ref_mem[m_addr[11:2]];
            end else begin
                e_ddone = 1;
                if (m_wr) ref_mem[m_addr[11:2]] = m_wd;
                else      e_drdata = ref_mem[m_addr[11:2]];
            end
            m_owner = 0;
        end
        e_status = 2'(m_owner);
        #1;
        chk("status",    64'(mem_status), 64'(e_status));
        chk("ram_en",    64'(ram_en),     64'(e_en));
        chk("ram_we",    64'(ram_we),     64'(e_we));
        chk("inst_done", 64'(inst_done),  64'(e_idone));
        chk("data_done", 64'(data_done),  64'(e_ddone));
        chk("inst_data", 64'(inst_data),  64'(e_idata));
        chk("data_rdat", 64'(data_rdata), 64'(e_drdata));
        chk("ram_addr",  64'(ram_addr),   64'(e_addr));
        chk("ram_wdata", 64'(ram_wdata),  64'(e_wdata));
        if (ram_en) begin
            en_hi++; last_en_addr = ram_addr; glog.push_back(int'(mem_status));
        end
        if (ram_we)    we_hi++;
        if (data_done) dd_hi++;
        if (e_idone) inst_sig = NOP;
        if (e_ddone) begin
            if (data_cont) begin data_sig = RD; data_addr = rnd_addr(); end
            else data_sig = NOP;
        end
    endtask

    // Step until the DUT pulses the chosen done, bounded; n = edges taken.
    task automatic wait_done(input bit inst, output int n);
        n = 0;
        do begin
            step(); n++;
        end while (!(inst ? inst_done : data_done) && n < 20);
    endtask

    initial begin
        int n, first_i;
        logic [LW-1:0] v;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom; ram[i] = v; ref_mem[i] = v;
        end
        ram[10'h040] = 32'h11223344; ref_mem[10'h040] = 32'h11223344;
        ram[10'h080] = 32'hA5A50200; ref_mem[10'h080] = 32'hA5A50200;
        model_reset();

        // Reset state
        repeat (2) step();
        #3 rst_n = 1'b1;

        // Single fetch: busy 2 cycles, done on the 3rd edge
        inst_sig = RD; inst_addr = 17'h100;
        wait_done(1, n);
        chk("lat_inst", 64'(n), 64'd3);
        chk("inst_word", 64'(inst_data), 64'h11223344);

        // Simultaneous fetch + load: load first, fetch at next idle
        we_hi = 0; glog.delete();
        inst_sig = RD; inst_addr = 17'h100; data_sig = RD; data_addr = 17'h200;
        wait_done(0, n);
        chk("lat_data_first", 64'(n), 64'd3);
        chk("load_word", 64'(data_rdata), 64'hA5A50200);
        wait_done(1, n);
        chk("lat_inst_next", 64'(n), 64'd3);
        chk("grant_order", 64'(glog.size() == 2 ? glog[0] * 10 + glog[1] : -1), 64'd21);
        chk("we_never", 64'(we_hi), 64'd0);

        // Store: one en+we cycle, load result untouched
        en_hi = 0; we_hi = 0;
        data_sig = WR; data_addr = 17'h40; data_wdata = 32'hDEADBEEF;
        wait_done(0, n);
        chk("lat_store", 64'(n), 64'd3);
        chk("store_en_cnt", 64'(en_hi), 64'd1);
        chk("store_we_cnt", 64'(we_hi), 64'd1);
        chk("store_addr", 64'(last_en_addr), 64'h40);
        chk("store_keeps_rdata", 64'(data_rdata), 64'hA5A50200);
        chk("ram_written", 64'(ram[10'h010]), 64'hDEADBEEF);

        // Withdrawn request still completes
        data_sig = RD; data_addr = 17'h200;
        step();
        data_sig = NOP;
        wait_done(0, n);
        chk("withdraw_done", 64'(n), 64'd2);

        // Fetch waits behind a continuous load stream
        glog.delete(); data_cont = 1;
        inst_sig = RD; inst_addr = 17'h300; data_sig = RD; data_addr = rnd_addr();
        repeat (18) step();
        first_i = -1;
        foreach (glog[j]) if (glog[j] == 1 && first_i < 0) first_i = j;
        chk("stream_grants", 64'(glog.size()), 64'd6);
`ifdef ARB_STARVE_GUARD_EN
        chk("starve_first_inst", 64'(first_i), 64'(SLIM));
`else
        chk("starve_first_inst", 64'(first_i), 64'(-1));
`endif
        data_cont = 0;
        repeat (10) step();

        // Reset during a load: no done, fetch wins first edge after release
        dd_hi = 0;
        inst_sig = RD; inst_addr = 17'h100; data_sig = RD; data_addr = 17'h200;
        step();
        chk("pre_rst_status", 64'(mem_status), 64'(ST_D));
        #3 rst_n = 1'b0; data_sig = NOP;
        #1 model_reset();
        chk("rst_status", 64'(mem_status), 64'(ST_R));
        chk("rst_en",     64'(ram_en),     64'd0);
        chk("rst_ddone",  64'(data_done),  64'd0);
        chk("rst_idata",  64'(inst_data),  64'd0);
        chk("rst_drdata", 64'(data_rdata), 64'd0);
        chk("rst_addr",   64'(ram_addr),   64'd0);
        chk("rst_wdata",  64'(ram_wdata),  64'd0);
        repeat (2) step();
        #3 rst_n = 1'b1;
        step();
        chk("post_rst_grant", 64'(mem_status), 64'(ST_I));
        wait_done(1, n);
        chk("post_rst_done", 64'(n), 64'd2);
        chk("no_ddone", 64'(dd_hi), 64'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step();
            if (inst_sig == NOP && $urandom_range(0, 3) == 0) begin
                inst_sig = RD; inst_addr = rnd_addr();
            end
            if (data_sig == NOP && $urandom_range(0, 2) == 0) begin
                data_sig   = ($urandom_range(0, 1) == 1) ? WR : RD;
                data_addr  = rnd_addr();
                data_wdata = $urandom;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1);
    end

endmodule
